// File: rtl/popcnt_iter_if.sv
// Issue/result bundle between the pipeline EX stage and the iterative bit-count unit.
interface popcnt_iter_if #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6,
    parameter int ACC_W = 16
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] numin;
    logic             flush;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] numout;
    logic [ACC_W-1:0] acc;

    // Pipeline side: issues requests and observes results.
    modport master (
        output start, op, numin, flush,
        input  busy, done, numout, acc
    );

    // Execution unit side.
    modport slave (
        input  start, op, numin, flush,
        output busy, done, numout, acc
    );
endinterface

// File: rtl/popcnt_iter_unit.sv
// Multi-cycle population-count unit: counts ones or zeros of an operand CHUNK bits
// per cycle, with an optional saturating accumulator. Busy/done mirror mult/div.
module popcnt_iter_unit #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 4,
    parameter int CNT_W = 6,
    parameter int ACC_W = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    popcnt_iter_if.slave    bus
);
    localparam int N      = WIDTH / CHUNK;
    localparam int BEAT_W = (N > 1) ? $clog2(N) : 1;

    localparam logic [1:0] OP_CNT1 = 2'b00;
    localparam logic [1:0] OP_CNT0 = 2'b01;
    localparam logic [1:0] OP_ACC1 = 2'b10;
    localparam logic [1:0] OP_ACLR = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_q;
    logic [WIDTH-1:0]   shreg_q;
    logic [CNT_W-1:0]   count_q;
    logic [BEAT_W-1:0]  beat_q;
    logic [1:0]         op_q;
    logic [CNT_W-1:0]   numout_q;
    logic [ACC_W-1:0]   acc_q;

    logic [CNT_W-1:0]   count_d;
    logic [ACC_W-1:0]   acc_d;
    logic               start_ok;

    // Number of set bits in one chunk.
    function automatic logic [CNT_W-1:0] popcnt_chunk(input logic [CHUNK-1:0] v);
        logic [CNT_W-1:0] n;
        n = '0;
        for (int i = 0; i < CHUNK; i++) begin
            n = n + {{(CNT_W-1){1'b0}}, v[i]};
        end
        return n;
    endfunction

    // Accumulate a zero-extended count, clamping at all-ones instead of wrapping.
    function automatic logic [ACC_W-1:0] sat_add(input logic [ACC_W-1:0] a,
                                                 input logic [CNT_W-1:0] c);
        logic [ACC_W:0] s;
        s = {1'b0, a} + {{(ACC_W+1-CNT_W){1'b0}}, c};
        return s[ACC_W] ? {ACC_W{1'b1}} : s[ACC_W-1:0];
    endfunction

    // Running sum including this beat's chunk, and the accumulator it would produce.
    always_comb begin
        count_d  = count_q + popcnt_chunk(shreg_q[CHUNK-1:0]);
        acc_d    = sat_add(acc_q, count_d);
        start_ok = (state_q != RUN) && bus.start && !bus.flush;
    end

    // Control FSM and datapath registers; flush always wins over start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            shreg_q  <= '0;
            count_q  <= '0;
            beat_q   <= '0;
            op_q     <= OP_CNT1;
            numout_q <= '0;
            acc_q    <= '0;
        end else begin
            case (state_q)
                RUN: begin
                    if (bus.flush) begin
                        state_q <= IDLE;
                    end else begin
                        count_q <= count_d;
                        shreg_q <= shreg_q >> CHUNK;
                        beat_q  <= beat_q + 1'b1;
                        if (beat_q == BEAT_W'(N - 1)) begin
                            numout_q <= count_d;
                            if (op_q == OP_ACC1) begin
                                acc_q <= acc_d;
                            end
                            state_q <= DONE;
                        end
                    end
                end
                default: begin
                    if (start_ok) begin
                        if (bus.op == OP_ACLR) begin
                            acc_q   <= '0;
                            state_q <= IDLE;
                        end else begin
                            shreg_q <= (bus.op == OP_CNT0) ? ~bus.numin : bus.numin;
                            count_q <= '0;
                            beat_q  <= '0;
                            op_q    <= bus.op;
                            state_q <= RUN;
                        end
                    end else begin
                        state_q <= IDLE;
                    end
                end
            endcase
        end
    end

    assign bus.busy   = (state_q == RUN);
    assign bus.done   = (state_q == DONE);
    assign bus.numout = numout_q;
    assign bus.acc    = acc_q;
endmodule

// File: tb/tb_popcnt_iter_unit.sv
// Directed testbench for popcnt_iter_unit with hand-computed expected values.
module tb_popcnt_iter_unit;
    logic clk;
    logic rst_n;
    int   n_checks = 0;
    int   n_errors = 0;

    popcnt_iter_if #(.WIDTH(32), .CNT_W(6), .ACC_W(16)) bus ();

    popcnt_iter_unit #(.WIDTH(32), .CHUNK(4), .CNT_W(6), .ACC_W(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge of the done cycle (or after a bound).
    task automatic run_op(input logic [1:0] o, input logic [31:0] n,
                          output int bcnt, output bit got);
        bus.start = 1'b1;
        bus.op    = o;
        bus.numin = n;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.op    = 2'b11;
        bus.numin = 32'hDEAD_BEEF;
        bcnt = 0;
        got  = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (bus.done) got = 1'b1;
            else if (bus.busy) bcnt++;
        end
    endtask

    initial begin
        int  bc;
        bit  g;
        bit  seen;
        int  miss;

        rst_n     = 1'b0;
        bus.start = 1'b0;
        bus.op    = 2'b00;
        bus.numin = '0;
        bus.flush = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("rst_busy",   {31'd0, bus.busy}, 32'd0);
        chk("rst_done",   {31'd0, bus.done}, 32'd0);
        chk("rst_numout", {26'd0, bus.numout}, 32'd0);
        chk("rst_acc",    {16'd0, bus.acc}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // 1: all ones
        run_op(2'b00, 32'hFFFF_FFFF, bc, g);
        chk("t1_busy_cycles", bc, 8);
        chk("t1_done", {31'd0, g}, 1);
        chk("t1_numout", {26'd0, bus.numout}, 32);
        chk("t1_acc", {16'd0, bus.acc}, 0);
        @(negedge clk);
        chk("t1_done_pulse", {31'd0, bus.done}, 0);
        chk("t1_idle_busy", {31'd0, bus.busy}, 0);

        // 2: count zeros, then back-to-back start from DONE
        run_op(2'b01, 32'h0000_00F0, bc, g);
        chk("t2_done", {31'd0, g}, 1);
        chk("t2_numout", {26'd0, bus.numout}, 28);
        run_op(2'b00, 32'h0000_0001, bc, g);
        chk("t2b_done", {31'd0, g}, 1);
        chk("t2b_busy_cycles", bc, 8);
        chk("t2b_numout", {26'd0, bus.numout}, 1);

        // 3: accumulate three times, then clear
        for (int k = 1; k <= 3; k++) begin
            run_op(2'b10, 32'h0F0F_0F0F, bc, g);
            chk($sformatf("t3_numout%0d", k), {26'd0, bus.numout}, 16);
            chk($sformatf("t3_acc%0d", k), {16'd0, bus.acc}, 16 * k);
        end
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = 2'b11;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        chk("t3_aclr_acc", {16'd0, bus.acc}, 0);
        chk("t3_aclr_busy", {31'd0, bus.busy}, 0);
        chk("t3_aclr_numout", {26'd0, bus.numout}, 16);
        @(negedge clk);
        chk("t3_aclr_nodone", {31'd0, bus.done}, 0);

        // 4: flush mid-run keeps the previous result
        run_op(2'b00, 32'h0000_001F, bc, g);
        chk("t4_prev_numout", {26'd0, bus.numout}, 5);
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = 2'b00;
        bus.numin = 32'h1234_5678;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (3) @(negedge clk);
        bus.flush = 1'b1;
        @(negedge clk);
        bus.flush = 1'b0;
        chk("t4_flush_busy", {31'd0, bus.busy}, 0);
        chk("t4_flush_numout", {26'd0, bus.numout}, 5);
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus.done || bus.busy) seen = 1'b1;
        end
        chk("t4_flush_quiet", {31'd0, seen}, 0);
        bus.start = 1'b1;
        bus.flush = 1'b1;
        bus.op    = 2'b10;
        bus.numin = 32'hFFFF_FFFF;
        @(negedge clk);
        bus.start = 1'b0;
        bus.flush = 1'b0;
        chk("t4_sf_busy", {31'd0, bus.busy}, 0);
        repeat (10) @(negedge clk);
        chk("t4_sf_numout", {26'd0, bus.numout}, 5);
        chk("t4_sf_acc", {16'd0, bus.acc}, 0);

        // 5: asynchronous reset in the middle of a run
        run_op(2'b10, 32'h0000_00FF, bc, g);
        chk("t5_pre_acc", {16'd0, bus.acc}, 8);
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = 2'b10;
        bus.numin = 32'hFFFF_FFFF;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (4) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t5_rst_busy", {31'd0, bus.busy}, 0);
        chk("t5_rst_done", {31'd0, bus.done}, 0);
        chk("t5_rst_numout", {26'd0, bus.numout}, 0);
        chk("t5_rst_acc", {16'd0, bus.acc}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_op(2'b00, 32'h8000_0001, bc, g);
        chk("t5_post_done", {31'd0, g}, 1);
        chk("t5_post_numout", {26'd0, bus.numout}, 2);

        // 6: accumulator saturation
        @(negedge clk);
        miss = 0;
        for (int k = 1; k <= 2047; k++) begin
            run_op(2'b10, 32'hFFFF_FFFF, bc, g);
            if (!g) miss++;
        end
        chk("t6_miss", miss, 0);
        chk("t6_acc2047", {16'd0, bus.acc}, 32'h0000_FFE0);
        run_op(2'b10, 32'hFFFF_FFFF, bc, g);
        chk("t6_acc2048", {16'd0, bus.acc}, 32'h0000_FFFF);
        run_op(2'b10, 32'hFFFF_FFFF, bc, g);
        chk("t6_acc2049", {16'd0, bus.acc}, 32'h0000_FFFF);
        chk("t6_numout2049", {26'd0, bus.numout}, 32);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
